// File: rtl/add_accum_if.sv
// Operand/result handshake bundle for add_accum_core.
// master = operand producer / result consumer, slave = the core.
interface add_accum_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             ovf_sticky;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, mode, clr, out_ready,
    input  in_ready, out_valid, result, carry, ovf, ovf_sticky, acc
  );

  modport slave (
    input  in_valid, a, b, mode, clr, out_ready,
    output in_ready, out_valid, result, carry, ovf, ovf_sticky, acc
  );
endinterface

// File: rtl/add_accum_core.sv
// Handshaked adder/accumulator: wrap/saturating add and accumulate with
// carry, per-result overflow and sticky overflow flags. One registered
// result per accepted operand transfer, one-cycle latency.
module add_accum_core #(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  add_accum_if.slave bus
);

  // mode encoding: bit1 selects accumulate, bit0 selects saturation
  localparam int MODE_ACC_BIT = 1;
  localparam int MODE_SAT_BIT = 0;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
  } rsp_t;

  rsp_t             rsp_q, rsp_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;

  logic             accept;
  logic             is_acc;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH:0]   raw;
  logic             sat;
  logic [WIDTH-1:0] val;

  // Ready only depends on the output slot draining; out_ready -> in_ready is
  // the single combinational path through the core.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_acc       = bus.mode[MODE_ACC_BIT];

  // Datapath: pick second operand, form the (WIDTH+1)-bit sum, clamp if asked.
  // A clear colliding with an accumulate makes the accumulator read as zero.
  always_comb begin
    opnd_b = bus.b;
    if (is_acc) opnd_b = bus.clr ? '0 : acc_q;
    raw = {1'b0, bus.a} + {1'b0, opnd_b};
    sat = bus.mode[MODE_SAT_BIT] && raw[WIDTH];
    val = sat ? '1 : raw[WIDTH-1:0];
  end

  // Next-state: output slot, accumulator and sticky flag.
  always_comb begin
    rsp_d       = rsp_q;
    out_valid_d = out_valid_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;

    if (bus.clr) begin
      acc_d    = '0;
      sticky_d = 1'b0;
    end

    if (accept) begin
      rsp_d.result = val;
      rsp_d.carry  = raw[WIDTH];
      rsp_d.ovf    = sat;
      out_valid_d  = 1'b1;
      // clear (if any) wins first, then this transfer's carry is ORed in
      sticky_d     = sticky_d | raw[WIDTH];
      if (is_acc) acc_d = val;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q       <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      rsp_q       <= rsp_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.result     = rsp_q.result;
  assign bus.carry      = rsp_q.carry;
  assign bus.ovf        = rsp_q.ovf;
  assign bus.ovf_sticky = sticky_q;
  assign bus.acc        = acc_q;

endmodule

// File: tb/tb_add_accum_core.sv
// Bench for add_accum_core: WIDTH=8 and WIDTH=16 instances share stimulus;
// a transfer-level model is compared every cycle, plus literal expectations.
module tb_add_accum_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // shared stimulus; 8-bit instance sees the low byte of operands
  logic        iv = 1'b0, ordy = 1'b0, cl = 1'b0;
  logic [1:0]  md = 2'b00;
  logic [15:0] av = '0, bv = '0;

  int n_vec = 0;
  int n_err = 0;

  add_accum_if #(.WIDTH(8))  b8 ();
  add_accum_if #(.WIDTH(16)) b16 ();

  assign b8.in_valid  = iv;   assign b16.in_valid  = iv;
  assign b8.out_ready = ordy; assign b16.out_ready = ordy;
  assign b8.clr       = cl;   assign b16.clr       = cl;
  assign b8.mode      = md;   assign b16.mode      = md;
  assign b8.a         = av[7:0];
  assign b8.b         = bv[7:0];
  assign b16.a        = av;
  assign b16.b        = bv;

  add_accum_core #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  add_accum_core #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transfer-level reference model ----------------
  // index 0 -> WIDTH 8, index 1 -> WIDTH 16
  int unsigned m_res[2], m_acc[2];
  bit          m_cy[2], m_ovf[2], m_stk[2];
  bit          m_ov;

  function automatic int unsigned lim_of(int k);
    return (k != 0) ? 32'd65536 : 32'd256;
  endfunction

  function automatic int unsigned raw_sum(int k, int unsigned accv);
    int unsigned l, op2;
    l   = lim_of(k);
    op2 = md[1] ? (cl ? 0 : accv) : (32'(bv) % l);
    return (32'(av) % l) + op2;
  endfunction

  function automatic int unsigned res_of(int k, int unsigned accv);
    int unsigned s, l;
    s = raw_sum(k, accv);
    l = lim_of(k);
    if (s >= l) return md[0] ? l - 1 : s - l;
    return s;
  endfunction

  wire m_accept = iv && (!m_ov || ordy);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_res[k] <= 0; m_acc[k] <= 0; m_cy[k] <= 1'b0; m_ovf[k] <= 1'b0; m_stk[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cl) begin
          m_acc[k] <= 0;
          m_stk[k] <= 1'b0;
        end
        if (m_accept) begin
          m_res[k] <= res_of(k, m_acc[k]);
          m_cy[k]  <= raw_sum(k, m_acc[k]) >= lim_of(k);
          m_ovf[k] <= md[0] && (raw_sum(k, m_acc[k]) >= lim_of(k));
          m_stk[k] <= (cl ? 1'b0 : m_stk[k]) | (raw_sum(k, m_acc[k]) >= lim_of(k));
          if (md[1]) m_acc[k] <= res_of(k, m_acc[k]);
        end
      end
      m_ov <= m_accept || (m_ov && !ordy);
    end
  end

  // every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m8_in_ready",   32'(b8.in_ready),   32'(!m_ov || ordy));
      chk("m8_out_valid",  32'(b8.out_valid),  32'(m_ov));
      chk("m8_result",     32'(b8.result),     m_res[0]);
      chk("m8_carry",      32'(b8.carry),      32'(m_cy[0]));
      chk("m8_ovf",        32'(b8.ovf),        32'(m_ovf[0]));
      chk("m8_sticky",     32'(b8.ovf_sticky), 32'(m_stk[0]));
      chk("m8_acc",        32'(b8.acc),        m_acc[0]);
      chk("m16_in_ready",  32'(b16.in_ready),  32'(!m_ov || ordy));
      chk("m16_out_valid", 32'(b16.out_valid), 32'(m_ov));
      chk("m16_result",    32'(b16.result),    m_res[1]);
      chk("m16_carry",     32'(b16.carry),     32'(m_cy[1]));
      chk("m16_ovf",       32'(b16.ovf),       32'(m_ovf[1]));
      chk("m16_sticky",    32'(b16.ovf_sticky),32'(m_stk[1]));
      chk("m16_acc",       32'(b16.acc),       m_acc[1]);
    end
  end

  // drive one cycle of stimulus, return 2 time units after the active edge
  task automatic cyc(input logic v, input logic [1:0] m, input logic [15:0] x,
                     input logic [15:0] y, input logic c, input logic r);
    iv = v; md = m; av = x; bv = y; cl = c; ordy = r;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(b8.out_valid), 0);
    chk("rst_result",    32'(b8.result), 0);
    chk("rst_acc",       32'(b8.acc), 0);
    chk("rst_sticky",    32'(b8.ovf_sticky), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready",  32'(b8.in_ready), 1);
    @(posedge clk); #2;

    // ADD vs ADD_SAT
    cyc(1, 2'b00, 16'h00F0, 16'h0020, 0, 1);
    chk("add_result", 32'(b8.result), 32'h10);
    chk("add_carry",  32'(b8.carry), 1);
    chk("add_ovf",    32'(b8.ovf), 0);
    chk("add_sticky", 32'(b8.ovf_sticky), 1);
    chk("add_valid",  32'(b8.out_valid), 1);
    chk("add16_result", 32'(b16.result), 32'h110);
    cyc(1, 2'b01, 16'h00F0, 16'h0020, 0, 1);
    chk("addsat_result", 32'(b8.result), 32'hFF);
    chk("addsat_ovf",    32'(b8.ovf), 1);
    cyc(1, 2'b01, 16'h0012, 16'h0034, 0, 1);
    chk("addsat2_result", 32'(b8.result), 32'h46);
    chk("addsat2_carry",  32'(b8.carry), 0);

    // clear then ACC 0x80 x3
    cyc(0, 2'b00, 0, 0, 1, 1);
    chk("clr_acc",    32'(b8.acc), 0);
    chk("clr_sticky", 32'(b8.ovf_sticky), 0);
    cyc(1, 2'b10, 16'h0080, 0, 0, 1);
    chk("acc1_result", 32'(b8.result), 32'h80);
    cyc(1, 2'b10, 16'h0080, 0, 0, 1);
    chk("acc2_result", 32'(b8.result), 32'h00);
    chk("acc2_carry",  32'(b8.carry), 1);
    cyc(1, 2'b10, 16'h0080, 0, 0, 1);
    chk("acc3_result", 32'(b8.result), 32'h80);
    chk("acc3_acc",    32'(b8.acc), 32'h80);

    // clear then ACC_SAT 0x80 x3
    cyc(0, 2'b00, 0, 0, 1, 1);
    cyc(1, 2'b11, 16'h0080, 0, 0, 1);
    chk("accs1_result", 32'(b8.result), 32'h80);
    chk("accs1_ovf",    32'(b8.ovf), 0);
    cyc(1, 2'b11, 16'h0080, 0, 0, 1);
    chk("accs2_result", 32'(b8.result), 32'hFF);
    chk("accs2_ovf",    32'(b8.ovf), 1);
    cyc(1, 2'b11, 16'h0080, 0, 0, 1);
    chk("accs3_result", 32'(b8.result), 32'hFF);
    chk("accs3_ovf",    32'(b8.ovf), 1);
    chk("accs3_acc",    32'(b8.acc), 32'hFF);

    // clr collisions
    cyc(1, 2'b10, 16'h0055, 0, 1, 1);
    chk("coll_pre_acc", 32'(b8.acc), 32'h55);
    cyc(1, 2'b10, 16'h0007, 0, 1, 1);
    chk("coll_acc_result", 32'(b8.result), 32'h07);
    chk("coll_acc_acc",    32'(b8.acc), 32'h07);
    chk("coll_acc_sticky", 32'(b8.ovf_sticky), 0);
    cyc(1, 2'b10, 16'h0055, 0, 1, 1);
    cyc(1, 2'b00, 16'h0001, 16'h0002, 1, 1);
    chk("coll_add_result", 32'(b8.result), 32'h03);
    chk("coll_add_acc",    32'(b8.acc), 0);

    // back-pressure: output must hold, nothing accepted
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b10, 16'h0011, 16'h0022, 0, 0);
      chk("bp_in_ready", 32'(b8.in_ready), 0);
      chk("bp_result",   32'(b8.result), 32'h03);
      chk("bp_valid",    32'(b8.out_valid), 1);
      chk("bp_acc",      32'(b8.acc), 0);
    end
    // release into a stream of ADDs, one result per cycle
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 2'b00, 16'(i), 16'(i), 0, 1);
      chk("stream_result", 32'(b8.result), 32'(2 * i));
      chk("stream_valid",  32'(b8.out_valid), 1);
    end

    // reset mid-operation with a pending result
    ordy = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(b8.out_valid), 0);
    chk("mrst_result",    32'(b8.result), 0);
    chk("mrst_carry",     32'(b16.carry), 0);
    chk("mrst_ovf",       32'(b8.ovf), 0);
    chk("mrst_acc",       32'(b16.acc), 0);
    chk("mrst_sticky",    32'(b8.ovf_sticky), 0);
    iv = 1'b0; cl = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    chk("mrst_in_ready", 32'(b8.in_ready), 1);
    @(posedge clk); #2;

    // random traffic, checked by the model every cycle
    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          16'($urandom), 16'($urandom),
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    cyc(0, 2'b00, 0, 0, 0, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
